// File: rtl/quad_steer_pkg.sv
// Shared phase constants, phase stepping helpers and direction type for quad_steer_gen.
package quad_steer_pkg;

  localparam int unsigned POS_W = 8;

  localparam logic [1:0] QPH_0 = 2'b00;
  localparam logic [1:0] QPH_1 = 2'b01;
  localparam logic [1:0] QPH_2 = 2'b11;
  localparam logic [1:0] QPH_3 = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INC  = 2'd1,
    DEC  = 2'd2
  } dir_e;

  // Next {A,B} in the increment direction: 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] phase_inc(input logic [1:0] ph);
    case (ph)
      QPH_0:   phase_inc = QPH_1;
      QPH_1:   phase_inc = QPH_2;
      QPH_2:   phase_inc = QPH_3;
      default: phase_inc = QPH_0;
    endcase
  endfunction

  // Next {A,B} in the decrement direction: reverse of phase_inc.
  function automatic logic [1:0] phase_dec(input logic [1:0] ph);
    case (ph)
      QPH_0:   phase_dec = QPH_3;
      QPH_3:   phase_dec = QPH_2;
      QPH_2:   phase_dec = QPH_1;
      default: phase_dec = QPH_0;
    endcase
  endfunction

endpackage

// File: rtl/quad_steer_channel.sv
// One steering channel: step divider, quadrature phase, position counter,
// external encoder synchroniser and auto-select of the output source.
// Optional paddle tracking is compiled in with QUAD_STEER_PADDLE_EN.
module quad_steer_channel
  import quad_steer_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [DIV_W-1:0] clkdiv,
  input  logic             left,
  input  logic             right,
  input  logic             paddle_mode,
  input  logic [POS_W-1:0] paddle,
  input  logic             ext_a,
  input  logic             ext_b,
  output logic             enc_a,
  output logic             enc_b,
  output logic             ext_active,
  output logic [POS_W-1:0] pos
);

  logic [1:0]       sync1, sync2, hist;
  logic [1:0]       phase, phase_n;
  logic [POS_W-1:0] pos_n;
  logic [DIV_W-1:0] divcnt, divcnt_n;
  logic             ext_active_n;
  logic [1:0]       enc_n;
  logic             step;
  logic             ext_chg;
  dir_e             dir;

  // Direction request: digital left/right, or chase the paddle target.
  always_comb begin
    dir = IDLE;
    case ({right, left})
      2'b10:   dir = INC;
      2'b01:   dir = DEC;
      default: dir = IDLE;
    endcase
`ifdef QUAD_STEER_PADDLE_EN
    if (paddle_mode) begin
      if (pos < paddle)      dir = INC;
      else if (pos > paddle) dir = DEC;
      else                   dir = IDLE;
    end
`endif
  end

`ifndef QUAD_STEER_PADDLE_EN
  // Paddle inputs have no function in the digital-only build.
  logic unused_paddle;
  assign unused_paddle = ^{paddle_mode, paddle};
`endif

  // Divider, step, and output source selection (internal step beats ext change).
  always_comb begin
    step     = 1'b0;
    divcnt_n = divcnt;
    phase_n  = phase;
    pos_n    = pos;
    if (dir == IDLE) begin
      divcnt_n = '0;
    end else if (divcnt == clkdiv) begin
      step     = 1'b1;
      divcnt_n = '0;
      if (dir == INC) begin
        phase_n = phase_inc(phase);
        pos_n   = pos + POS_W'(1);
      end else begin
        phase_n = phase_dec(phase);
        pos_n   = pos - POS_W'(1);
      end
    end else begin
      divcnt_n = divcnt + DIV_W'(1);
    end

    ext_chg = (sync2 != hist);
    if (step)         ext_active_n = 1'b0;
    else if (ext_chg) ext_active_n = 1'b1;
    else              ext_active_n = ext_active;

    enc_n = ext_active_n ? sync2 : phase_n;
  end

  // State and registered outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1      <= 2'b00;
      sync2      <= 2'b00;
      hist       <= 2'b00;
      phase      <= QPH_0;
      pos        <= '0;
      divcnt     <= '0;
      ext_active <= 1'b0;
      enc_a      <= 1'b0;
      enc_b      <= 1'b0;
    end else begin
      sync1      <= {ext_a, ext_b};
      sync2      <= sync1;
      hist       <= sync2;
      phase      <= phase_n;
      pos        <= pos_n;
      divcnt     <= divcnt_n;
      ext_active <= ext_active_n;
      enc_a      <= enc_n[1];
      enc_b      <= enc_n[0];
    end
  end

endmodule

// File: rtl/quad_steer_gen.sv
// Multi-channel quadrature steering generator; slices buses into channels.
// Paddle tracking is compiled in when QUAD_STEER_PADDLE_EN is defined.
module quad_steer_gen
  import quad_steer_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DIV_W    = 16
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [DIV_W-1:0]      clkdiv,
  input  logic [CHANNELS-1:0]   left,
  input  logic [CHANNELS-1:0]   right,
  input  logic [CHANNELS-1:0]   paddle_mode,
  input  logic [CHANNELS*8-1:0] paddle,
  input  logic [CHANNELS-1:0]   ext_a,
  input  logic [CHANNELS-1:0]   ext_b,
  output logic [CHANNELS-1:0]   enc_a,
  output logic [CHANNELS-1:0]   enc_b,
  output logic [CHANNELS-1:0]   ext_active,
  output logic [CHANNELS*8-1:0] pos
);

  // One independent channel per steering input.
  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    quad_steer_channel #(.DIV_W(DIV_W)) u_ch (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .clkdiv      (clkdiv),
      .left        (left[i]),
      .right       (right[i]),
      .paddle_mode (paddle_mode[i]),
      .paddle      (paddle[8*i +: 8]),
      .ext_a       (ext_a[i]),
      .ext_b       (ext_b[i]),
      .enc_a       (enc_a[i]),
      .enc_b       (enc_b[i]),
      .ext_active  (ext_active[i]),
      .pos         (pos[8*i +: 8])
    );
  end

endmodule

// File: tb/tb_quad_steer_gen.sv
// Self-checking bench for quad_steer_gen: cycle model feeds a scoreboard queue,
// scenario tasks add fixed expectations from the intended behaviour.
module tb_quad_steer_gen;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [15:0] clkdiv;
  logic [1:0]  left, right, paddle_mode, ext_a, ext_b;
  logic [15:0] paddle;
  logic [1:0]  enc_a, enc_b, ext_active;
  logic [15:0] pos;

  typedef struct packed {
    logic [1:0]  a;
    logic [1:0]  b;
    logic [1:0]  act;
    logic [15:0] pos;
  } exp_t;

  exp_t obs;
  assign obs = {enc_a, enc_b, ext_active, pos};

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  quad_steer_gen #(.CHANNELS(2), .DIV_W(16)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .clkdiv      (clkdiv),
    .left        (left),
    .right       (right),
    .paddle_mode (paddle_mode),
    .paddle      (paddle),
    .ext_a       (ext_a),
    .ext_b       (ext_b),
    .enc_a       (enc_a),
    .enc_b       (enc_b),
    .ext_active  (ext_active),
    .pos         (pos)
  );

  always #5 clk_sys = ~clk_sys;

  // Behavioural cycle model: one expected output snapshot per rising edge.
  int         m_idx [2];
  int         m_pos [2];
  int         m_div [2];
  logic       m_act [2];
  logic [1:0] m_s1 [2], m_s2 [2], m_h [2], m_enc [2];
  logic       m_chg, m_stp;
  logic [1:0] m_syn;
  int         m_d;
  exp_t       m_e;

  always @(posedge clk_sys) begin
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        m_idx[c] = 0; m_pos[c] = 0; m_div[c] = 0; m_act[c] = 1'b0;
        m_s1[c] = 2'b00; m_s2[c] = 2'b00; m_h[c] = 2'b00; m_enc[c] = 2'b00;
      end else begin
        m_chg = (m_s2[c] != m_h[c]);
        m_syn = m_s2[c];
        m_h[c]  = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = {ext_a[c], ext_b[c]};
        m_d = 0;
        if (right[c] && !left[c]) m_d = 1;
        else if (left[c] && !right[c]) m_d = -1;
`ifdef QUAD_STEER_PADDLE_EN
        if (paddle_mode[c]) begin
          if (m_pos[c] < int'(paddle[8*c +: 8]))      m_d = 1;
          else if (m_pos[c] > int'(paddle[8*c +: 8])) m_d = -1;
          else                                         m_d = 0;
        end
`endif
        m_stp = 1'b0;
        if (m_d == 0) m_div[c] = 0;
        else if (m_div[c] == int'(clkdiv)) begin
          m_div[c] = 0;
          m_idx[c] = (m_idx[c] + m_d + 4) % 4;
          m_pos[c] = (m_pos[c] + m_d + 256) % 256;
          m_stp = 1'b1;
        end else m_div[c] = (m_div[c] + 1) % 65536;
        if (m_stp) m_act[c] = 1'b0;
        else if (m_chg) m_act[c] = 1'b1;
        m_enc[c] = m_act[c] ? m_syn : gray[m_idx[c]];
      end
      m_e.a[c]   = m_enc[c][1];
      m_e.b[c]   = m_enc[c][0];
      m_e.act[c] = m_act[c];
      m_e.pos[8*c +: 8] = 8'(m_pos[c]);
    end
    sb.push_back(m_e);
  end

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      while (sb.size() > 1) void'(sb.pop_front());
      n_total++;
      if (sb.size() == 0) $display("FAIL reset_model: got no entry want one");
      else begin
        e = sb.pop_front();
        if (obs !== e) $display("FAIL reset_model: got %h want %h", obs, e); else n_pass++;
      end
      n_total++;
      if (obs !== 22'h0) $display("FAIL reset_values: got %h want %h", obs, 22'h0); else n_pass++;
    end
    reset = 1'b0;
  endtask

  task automatic test_digital();
    exp_t e;
    do_reset();
    clkdiv = 16'd3; right = 2'b01;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_sys);
      while (sb.size() > 1) void'(sb.pop_front());
      n_total++;
      if (sb.size() == 0) $display("FAIL digital_model: got no entry want one");
      else begin
        e = sb.pop_front();
        if (obs !== e) $display("FAIL digital_model: got %h want %h", obs, e); else n_pass++;
      end
      if (i % 4 == 0) begin
        n_total++;
        if ({enc_a[0], enc_b[0]} !== gray[(i / 4) % 4])
          $display("FAIL digital_phase_c%0d: got %b want %b", i, {enc_a[0], enc_b[0]}, gray[(i / 4) % 4]);
        else n_pass++;
      end
    end
    right = 2'b00;
    n_total++;
    if (pos[7:0] !== 8'h05) $display("FAIL digital_pos: got %h want 05", pos[7:0]); else n_pass++;
    n_total++;
    if ({enc_a[1], enc_b[1], ext_active[1], pos[15:8]} !== 11'h0)
      $display("FAIL digital_ch1_idle: got %h want 000", {enc_a[1], enc_b[1], ext_active[1], pos[15:8]});
    else n_pass++;
  endtask

  task automatic test_conflict_wrap();
    exp_t e;
    do_reset();
    clkdiv = 16'd3;
    for (int i = 0; i < 14; i++) begin
      if (i < 4 || i == 6) begin left = 2'b01; right = 2'b01; end
      else begin left = 2'b00; right = 2'b01; end
      @(negedge clk_sys);
      while (sb.size() > 1) void'(sb.pop_front());
      n_total++;
      if (sb.size() == 0) $display("FAIL conflict_model: got no entry want one");
      else begin
        e = sb.pop_front();
        if (obs !== e) $display("FAIL conflict_model: got %h want %h", obs, e); else n_pass++;
      end
      if (i == 9) begin
        n_total++;
        if (pos[7:0] !== 8'h00) $display("FAIL conflict_divclear: got %h want 00", pos[7:0]); else n_pass++;
      end
      if (i == 10) begin
        n_total++;
        if (pos[7:0] !== 8'h01) $display("FAIL conflict_resume: got %h want 01", pos[7:0]); else n_pass++;
      end
    end
    left = 2'b00; right = 2'b00;
    do_reset();
    clkdiv = 16'd0; left = 2'b01;
    @(negedge clk_sys);
    left = 2'b00;
    n_total++;
    if (pos[7:0] !== 8'hFF) $display("FAIL wrap_pos: got %h want ff", pos[7:0]); else n_pass++;
    n_total++;
    if ({enc_a[0], enc_b[0]} !== 2'b10) $display("FAIL wrap_phase: got %b want 10", {enc_a[0], enc_b[0]}); else n_pass++;
  endtask

`ifdef QUAD_STEER_PADDLE_EN
  task automatic test_paddle();
    exp_t e;
    do_reset();
    clkdiv = 16'd0; paddle_mode = 2'b01; paddle = 16'h0005;
    for (int i = 1; i <= 14; i++) begin
      if (i == 9) paddle = 16'h0002;
      @(negedge clk_sys);
      while (sb.size() > 1) void'(sb.pop_front());
      n_total++;
      if (sb.size() == 0) $display("FAIL paddle_model: got no entry want one");
      else begin
        e = sb.pop_front();
        if (obs !== e) $display("FAIL paddle_model: got %h want %h", obs, e); else n_pass++;
      end
      if (i == 8) begin
        n_total++;
        if ({enc_a[0], enc_b[0], pos[7:0]} !== {2'b01, 8'h05})
          $display("FAIL paddle_up: got %h want 105", {enc_a[0], enc_b[0], pos[7:0]});
        else n_pass++;
      end
      if (i == 11 || i == 14) begin
        n_total++;
        if ({enc_a[0], enc_b[0], pos[7:0]} !== {2'b11, 8'h02})
          $display("FAIL paddle_down_c%0d: got %h want 302", i, {enc_a[0], enc_b[0], pos[7:0]});
        else n_pass++;
      end
    end
    paddle_mode = 2'b00;
  endtask
`else
  task automatic test_macro_off();
    exp_t e;
    do_reset();
    clkdiv = 16'd0; paddle_mode = 2'b01; paddle = 16'h0010; right = 2'b01;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_sys);
      while (sb.size() > 1) void'(sb.pop_front());
      n_total++;
      if (sb.size() == 0) $display("FAIL macro_off_model: got no entry want one");
      else begin
        e = sb.pop_front();
        if (obs !== e) $display("FAIL macro_off_model: got %h want %h", obs, e); else n_pass++;
      end
    end
    right = 2'b00; paddle_mode = 2'b00;
    n_total++;
    if ({enc_a[0], enc_b[0], pos[7:0]} !== {2'b00, 8'h14})
      $display("FAIL macro_off_pos: got %h want 014", {enc_a[0], enc_b[0], pos[7:0]});
    else n_pass++;
  endtask
`endif

  task automatic test_auto_select();
    exp_t e;
    ext_a = 2'b00; ext_b = 2'b00;
    do_reset();
    ext_a = 2'b01;
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) begin clkdiv = 16'd0; right = 2'b01; end
      if (i == 5) begin clkdiv = 16'd2; right = 2'b01; ext_b = 2'b01; end
      @(negedge clk_sys);
      while (sb.size() > 1) void'(sb.pop_front());
      n_total++;
      if (sb.size() == 0) $display("FAIL auto_model: got no entry want one");
      else begin
        e = sb.pop_front();
        if (obs !== e) $display("FAIL auto_model: got %h want %h", obs, e); else n_pass++;
      end
      if (i == 2) begin
        n_total++;
        if (ext_active !== 2'b00) $display("FAIL auto_early: got %b want 00", ext_active); else n_pass++;
      end
      if (i == 3) begin
        n_total++;
        if ({ext_active, enc_a[0], enc_b[0]} !== 4'b0110)
          $display("FAIL auto_set: got %b want 0110", {ext_active, enc_a[0], enc_b[0]});
        else n_pass++;
      end
      if (i == 4) begin
        n_total++;
        if ({ext_active[0], enc_a[0], enc_b[0]} !== 3'b001)
          $display("FAIL auto_clear: got %b want 001", {ext_active[0], enc_a[0], enc_b[0]});
        else n_pass++;
      end
      if (i == 7) begin
        n_total++;
        if ({ext_active[0], enc_a[0], enc_b[0]} !== 3'b011)
          $display("FAIL auto_simul: got %b want 011", {ext_active[0], enc_a[0], enc_b[0]});
        else n_pass++;
        right = 2'b00;
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    ext_a = 2'b00; ext_b = 2'b00;
    do_reset();
    clkdiv = 16'd0; right = 2'b01;
    for (int i = 1; i <= 71; i++) begin
      if (i == 65) clkdiv = 16'd3;
      if (i == 67) reset = 1'b1;
      if (i == 68) reset = 1'b0;
      @(negedge clk_sys);
      while (sb.size() > 1) void'(sb.pop_front());
      n_total++;
      if (sb.size() == 0) $display("FAIL rstmid_model: got no entry want one");
      else begin
        e = sb.pop_front();
        if (obs !== e) $display("FAIL rstmid_model: got %h want %h", obs, e); else n_pass++;
      end
      if (i == 64) begin
        n_total++;
        if (pos[7:0] !== 8'h40) $display("FAIL rstmid_pos40: got %h want 40", pos[7:0]); else n_pass++;
      end
      if (i == 67) begin
        n_total++;
        if (obs !== 22'h0) $display("FAIL rstmid_values: got %h want %h", obs, 22'h0); else n_pass++;
      end
      if (i == 70) begin
        n_total++;
        if (pos[7:0] !== 8'h00) $display("FAIL rstmid_hold: got %h want 00", pos[7:0]); else n_pass++;
      end
    end
    right = 2'b00;
    n_total++;
    if ({enc_a[0], enc_b[0], pos[7:0]} !== {2'b01, 8'h01})
      $display("FAIL rstmid_resume: got %h want 101", {enc_a[0], enc_b[0], pos[7:0]});
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; clkdiv = 16'd0; left = 2'b00; right = 2'b00;
    paddle_mode = 2'b00; paddle = 16'h0000; ext_a = 2'b00; ext_b = 2'b00;
    test_reset();
    test_digital();
    test_conflict_wrap();
`ifdef QUAD_STEER_PADDLE_EN
    test_paddle();
`else
    test_macro_off();
`endif
    test_auto_select();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/quad_steer_gen.md
# quad_steer_gen

Multi-channel quadrature steering generator for arcade paddle cores. Converts digital left/right controls, or an absolute 8-bit paddle position, into two-phase quadrature A/B streams that drive the core's spinner/encoder inputs. It auto-selects a physical encoder on the user port whenever that encoder moves. It sits between hps_io/USER_IN and the game core, and generalises the single-channel joystick-to-quadrature path to N channels with a position-tracking mode.

## Interface
- CHANNELS, 2, number of independent steering channels (1–4)
- DIV_W, 16, width of step-rate divider
- clk_sys  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- clkdiv  in  DIV_W  step period minus one, shared by all channels; a step occurs every clkdiv+1 cycles
- left  in  CHANNELS  digital move-decrement request per channel
- right  in  CHANNELS  digital move-increment request per channel
- paddle_mode  in  CHANNELS  1 = track absolute paddle target (only with macro)
- paddle  in  CHANNELS*8  absolute target per channel, channel i at [8i+7:8i]
- ext_a, ext_b  in  CHANNELS  raw external encoder phases (asynchronous)
- enc_a, enc_b  out  CHANNELS  quadrature outputs to core
- ext_active  out  CHANNELS  1 = outputs currently sourced from external encoder
- pos  out  CHANNELS*8  internal position counter per channel

## Operation
- Phase sequence {A,B}: 00→01→11→10→00 for an increment; reverse order for a decrement.
- Per channel, direction request: digital mode gives inc = right & ~left, dec = left & ~right; both or neither = idle. Paddle mode gives inc when pos < target, dec when pos > target, idle when equal. There is no wrap in paddle mode.
- Divider per channel, divcnt: cleared while idle. While requested: if divcnt == clkdiv, do the step and set divcnt to 0; otherwise increment divcnt.
- A step advances the phase one position and sets pos to pos±1. pos wraps modulo 256 in digital mode.
- A mode change or a direction change mid-count keeps pos, phase and divcnt. An idle cycle clears divcnt.
- External source: ext_a/ext_b pass through a 2-FF synchroniser, then a 1-cycle history register.
  - A change in the synchronised pair sets ext_active.
  - A change of the internal phase clears ext_active.
  - If both changes happen in the same cycle, the clear wins.
- Output mux: {enc_a,enc_b} = ext_active ? synced ext pair : internal phase.

## Timing
- Reset values: phase 00, pos 0x00, divcnt 0, ext_active 0, synchronisers 00, enc_a/enc_b 0.
- Request asserted in cycle t and held: the first phase change is visible on the outputs at cycle t+clkdiv+1. Later changes follow every clkdiv+1 cycles. With clkdiv=0, the phase steps every cycle.
- External edge to ext_active=1 and the outputs following it: 3 cycles.
- Reset asserted mid-count aborts the step. The next cycle shows the reset values.
- clkdiv changes take effect at the next comparison. If divcnt is greater than a new, smaller clkdiv, the counter counts through the DIV_W wrap.

## Configuration
- QUAD_STEER_PADDLE_EN defined: paddle-tracking mode is compiled in as described.
- Not defined: paddle_mode and paddle are ignored. Every channel is in digital mode and pos always wraps. The comparator logic is absent.

## Structure
- quad_steer_pkg holds:
  - phase constants QPH_0..QPH_3
  - the functions phase_inc/phase_dec
  - the typedef for direction request (IDLE, INC, DEC)
- Sub-module quad_steer_channel holds one channel's divider, phase, pos, synchroniser and auto-select. The top instantiates it CHANNELS times in a generate loop and only slices the buses.

## Test plan
- Digital steps: clkdiv=3, right[0]=1 for 20 cycles → phase 01,11,10,00,01 at cycles 4,8,12,16,20; pos=5; channel 1 unchanged.
- Conflict and wrap: left=right=1 → no step and divcnt 0. Then left only, from pos 0 with clkdiv=0 → pos 0xFF after 1 cycle, phase 10.
- Paddle tracking (macro on): paddle_mode=1, paddle=0x05, clkdiv=0, pos 0 → exactly 5 steps, then idle at pos 0x05. Set target 0x02 → 3 decrement steps.
- Auto-select: toggle ext_a on channel 0 → ext_active=1 three cycles later and enc mirrors ext. Then one internal step → ext_active=0 on that cycle. A simultaneous ext change and internal step → ext_active=0.
- Reset mid-operation: assert reset during a count with pos=0x40 → next cycle shows pos 0, phase 00, ext_active 0. Motion resumes clkdiv+1 cycles after reset is released.
- Macro off: paddle_mode=1, paddle=0x10, right=1 → digital behaviour; the paddle value has no effect.
